// File: rtl/cm0ik_rstctrl_if.sv
// Reset-controller signal bundle: core reset requests in, reset domains and status out.
// The core side is the master and the reset controller is the slave.
interface cm0ik_rstctrl_if #(
    parameter int CNT_W = 8
);
    logic             SYSRESETREQ;
    logic             LOCKUP;
    logic             DBGRESETn;
    logic             HRESETn;
    logic [1:0]       RSTCAUSE;
    logic [CNT_W-1:0] SYSRST_COUNT;

    modport master (
        output SYSRESETREQ, LOCKUP,
        input  DBGRESETn, HRESETn, RSTCAUSE, SYSRST_COUNT
    );

    modport slave (
        input  SYSRESETREQ, LOCKUP,
        output DBGRESETn, HRESETn, RSTCAUSE, SYSRST_COUNT
    );
endinterface

// File: rtl/cm0ik_rstctrl.sv
// Cortex-M0 integration-kit reset controller: synchronises POR release to HCLK and
// sequences the debug and system reset domains, recording cause and reset count.
module cm0ik_rstctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int POR_STRETCH = 4,
    parameter int SYS_STRETCH = 3,
    parameter int LOCKUP_EN   = 1,
    parameter int CNT_W       = 8
) (
    input  logic           HCLK,
    input  logic           PORESET,
    cm0ik_rstctrl_if.slave bus
);
    localparam int MAXS = (POR_STRETCH > SYS_STRETCH) ? POR_STRETCH : SYS_STRETCH;
    localparam int CW   = (MAXS > 1) ? $clog2(MAXS) : 1;

    localparam logic [CW-1:0] POR_LOAD  = CW'(POR_STRETCH - 1);
    localparam logic [CW-1:0] SYS_LOAD  = CW'(SYS_STRETCH - 1);
    localparam logic          LOCKUP_ON = (LOCKUP_EN != 0);

    localparam logic [1:0] S_POR     = 2'd0;
    localparam logic [1:0] S_STRETCH = 2'd1;
    localparam logic [1:0] S_RUN     = 2'd2;
    localparam logic [1:0] S_SYSRST  = 2'd3;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [1:0]             r_state;
    logic [CW-1:0]          r_cnt;
    logic                   r_hrstn;
    logic [1:0]             r_cause;
    logic [CNT_W-1:0]       r_count;
    logic                   w_trigger;

    assign w_trigger = bus.SYSRESETREQ | (bus.LOCKUP & LOCKUP_ON);

    always_ff @(posedge HCLK or posedge PORESET) begin
        if (PORESET) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // The FSM only looks at synchroniser stages, never at PORESET's raw release,
    // and ignores the core inputs until S_RUN so X there cannot leak in.
    always_ff @(posedge HCLK or posedge PORESET) begin
        if (PORESET) begin
            r_state <= S_POR;
            r_cnt   <= '0;
            r_hrstn <= 1'b0;
            r_cause <= 2'b00;
            r_count <= '0;
        end else begin
            case (r_state)
                S_POR: begin
                    if (r_sync[SYNC_STAGES-2]) begin
                        r_state <= S_STRETCH;
                        r_cnt   <= POR_LOAD;
                    end
                end
                S_STRETCH: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_hrstn <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_trigger) begin
                        r_hrstn <= 1'b0;
                        r_cnt   <= SYS_LOAD;
                        r_cause <= bus.SYSRESETREQ ? 2'b01 : 2'b10;
                        if (r_count != '1) begin
                            r_count <= r_count + 1'b1;
                        end
                        r_state <= S_SYSRST;
                    end
                end
                S_SYSRST: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (!w_trigger) begin
                        r_hrstn <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                default: r_state <= S_POR;
            endcase
        end
    end

    assign bus.DBGRESETn    = r_sync[SYNC_STAGES-1];
    assign bus.HRESETn      = r_hrstn;
    assign bus.RSTCAUSE     = r_cause;
    assign bus.SYSRST_COUNT = r_count;
endmodule

// File: tb/tb_cm0ik_rstctrl.sv
// Directed bench for cm0ik_rstctrl: three instances cover default parameters,
// LOCKUP_EN=0 and a 2-bit saturating counter.
module tb_cm0ik_rstctrl;
    logic HCLK;
    logic PORESET;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         dut;
        logic       req;
        logic       lock;
        logic       expH;
        logic [1:0] expC;
        int         expN;
    } vec_t;

    vec_t vecs[$];

    cm0ik_rstctrl_if #(.CNT_W(8)) ifA ();
    cm0ik_rstctrl_if #(.CNT_W(8)) ifB ();
    cm0ik_rstctrl_if #(.CNT_W(2)) ifC ();

    cm0ik_rstctrl uA (.HCLK(HCLK), .PORESET(PORESET), .bus(ifA.slave));
    cm0ik_rstctrl #(.LOCKUP_EN(0)) uB (.HCLK(HCLK), .PORESET(PORESET), .bus(ifB.slave));
    cm0ik_rstctrl #(.CNT_W(2)) uC (.HCLK(HCLK), .PORESET(PORESET), .bus(ifC.slave));

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic readDut(input int d, output logic h, output logic dbg,
                           output logic [1:0] c, output logic [31:0] n);
        case (d)
            0: begin h = ifA.HRESETn; dbg = ifA.DBGRESETn; c = ifA.RSTCAUSE; n = 32'(ifA.SYSRST_COUNT); end
            1: begin h = ifB.HRESETn; dbg = ifB.DBGRESETn; c = ifB.RSTCAUSE; n = 32'(ifB.SYSRST_COUNT); end
            default: begin h = ifC.HRESETn; dbg = ifC.DBGRESETn; c = ifC.RSTCAUSE; n = 32'(ifC.SYSRST_COUNT); end
        endcase
    endtask

    task automatic addVec(input int d, input logic rq, input logic lk, input logic h,
                          input logic [1:0] c, input int n);
        vec_t v;
        v.dut = d; v.req = rq; v.lock = lk; v.expH = h; v.expC = c; v.expN = n;
        vecs.push_back(v);
    endtask

    task automatic clearInputs();
        ifA.SYSRESETREQ = 1'b0; ifA.LOCKUP = 1'b0;
        ifB.SYSRESETREQ = 1'b0; ifB.LOCKUP = 1'b0;
        ifC.SYSRESETREQ = 1'b0; ifC.LOCKUP = 1'b0;
    endtask

    // Drives one vector at the falling edge, lets one rising edge pass, samples at the next falling edge.
    task automatic applyStimulus(input vec_t v, input int idx);
        logic h, dbg;
        logic [1:0] c;
        logic [31:0] n;
        clearInputs();
        case (v.dut)
            0: begin ifA.SYSRESETREQ = v.req; ifA.LOCKUP = v.lock; end
            1: begin ifB.SYSRESETREQ = v.req; ifB.LOCKUP = v.lock; end
            default: begin ifC.SYSRESETREQ = v.req; ifC.LOCKUP = v.lock; end
        endcase
        @(posedge HCLK);
        @(negedge HCLK);
        readDut(v.dut, h, dbg, c, n);
        checkOutput($sformatf("vec%0d_dut%0d_HRESETn", idx, v.dut), 32'(h), 32'(v.expH));
        checkOutput($sformatf("vec%0d_dut%0d_DBGRESETn", idx, v.dut), 32'(dbg), 32'd1);
        checkOutput($sformatf("vec%0d_dut%0d_RSTCAUSE", idx, v.dut), 32'(c), 32'(v.expC));
        checkOutput($sformatf("vec%0d_dut%0d_COUNT", idx, v.dut), n, 32'(v.expN));
    endtask

    // Checks every instance is fully in reset right now.
    task automatic checkAllReset(input string tag);
        logic h, dbg;
        logic [1:0] c;
        logic [31:0] n;
        for (int d = 0; d < 3; d++) begin
            readDut(d, h, dbg, c, n);
            checkOutput($sformatf("%s_dut%0d_HRESETn", tag, d), 32'(h), 32'd0);
            checkOutput($sformatf("%s_dut%0d_DBGRESETn", tag, d), 32'(dbg), 32'd0);
            checkOutput($sformatf("%s_dut%0d_RSTCAUSE", tag, d), 32'(c), 32'd0);
            checkOutput($sformatf("%s_dut%0d_COUNT", tag, d), n, 32'd0);
        end
    endtask

    // After PORESET falls mid-cycle: DBGRESETn rises at edge 2, HRESETn at edge 6.
    task automatic checkRelease(input string tag);
        logic h, dbg;
        logic [1:0] c;
        logic [31:0] n;
        for (int k = 1; k <= 7; k++) begin
            @(posedge HCLK);
            @(negedge HCLK);
            for (int d = 0; d < 3; d++) begin
                readDut(d, h, dbg, c, n);
                checkOutput($sformatf("%s_e%0d_dut%0d_DBGRESETn", tag, k, d), 32'(dbg), 32'(k >= 2));
                checkOutput($sformatf("%s_e%0d_dut%0d_HRESETn", tag, k, d), 32'(h), 32'(k >= 6));
                checkOutput($sformatf("%s_e%0d_dut%0d_RSTCAUSE", tag, k, d), 32'(c), 32'd0);
                checkOutput($sformatf("%s_e%0d_dut%0d_COUNT", tag, k, d), n, 32'd0);
            end
        end
    endtask

    initial begin
        // Single request pulse: low for exactly three edges.
        addVec(0, 1, 0, 0, 2'b01, 1);
        addVec(0, 0, 0, 0, 2'b01, 1);
        addVec(0, 0, 0, 0, 2'b01, 1);
        addVec(0, 0, 0, 1, 2'b01, 1);
        addVec(0, 0, 0, 1, 2'b01, 1);
        // Request held six edges: one count, release on first edge it is low.
        for (int i = 0; i < 6; i++) addVec(0, 1, 0, 0, 2'b01, 2);
        addVec(0, 0, 0, 1, 2'b01, 2);
        // Both together: SYSRESETREQ wins.
        addVec(0, 1, 1, 0, 2'b01, 3);
        addVec(0, 0, 0, 0, 2'b01, 3);
        addVec(0, 0, 0, 0, 2'b01, 3);
        addVec(0, 0, 0, 1, 2'b01, 3);
        // LOCKUP alone, then a request during the stretch that must not count.
        addVec(0, 0, 1, 0, 2'b10, 4);
        addVec(0, 1, 0, 0, 2'b10, 4);
        addVec(0, 0, 0, 0, 2'b10, 4);
        addVec(0, 0, 0, 1, 2'b10, 4);
        // LOCKUP_EN=0: lockup ignored, request still honoured.
        for (int i = 0; i < 3; i++) addVec(1, 0, 1, 1, 2'b00, 0);
        addVec(1, 1, 0, 0, 2'b01, 1);
        addVec(1, 0, 0, 0, 2'b01, 1);
        addVec(1, 0, 0, 0, 2'b01, 1);
        addVec(1, 0, 0, 1, 2'b01, 1);
        // Two-bit counter saturates at 3.
        for (int p = 1; p <= 5; p++) begin
            addVec(2, 1, 0, 0, 2'b01, (p > 3) ? 3 : p);
            addVec(2, 0, 0, 0, 2'b01, (p > 3) ? 3 : p);
            addVec(2, 0, 0, 0, 2'b01, (p > 3) ? 3 : p);
            addVec(2, 0, 0, 1, 2'b01, (p > 3) ? 3 : p);
        end

        clearInputs();
        PORESET = 1'b1;
        repeat (5) @(posedge HCLK);
        @(negedge HCLK);
        checkAllReset("por_held");
        PORESET = 1'b0;
        checkRelease("por1");

        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

        // Park dut0 in its system reset with one stretch cycle left, then glitch PORESET.
        begin
            vec_t v;
            v.dut = 0; v.req = 1; v.lock = 0; v.expH = 0; v.expC = 2'b01; v.expN = 5;
            applyStimulus(v, 900);
            v.req = 0;
            applyStimulus(v, 901);
        end
        #1 PORESET = 1'b1;
        #1 checkAllReset("glitch");
        #1 PORESET = 1'b0;
        checkRelease("por2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
